jtag_debug_cmd_sync: RTL and testbench

Parametrised successor to the JTAG debug module's system-clock command path. It synchronises the virtual-JTAG update strobes (vs_uir, vs_udr) from the TCK domain into clk, and latches the instruction register. Each data update is captured with its IR channel into a small command FIFO, and commands are delivered to the debug core under a valid/ready handshake as per-channel take_action / take_no_action pulses plus a registered jdo word. Generalised over data width, IR width (channel count), synchroniser depth and queue depth; adds back-pressure and overflow reporting, which the previous generation lacked.

---
 rtl/jtag_debug_cmd_sync_pkg.sv | 28 ++
 rtl/jtag_debug_cmd_sync_if.sv | 23 ++
 rtl/jtag_debug_cmd_sync_strobe.sv | 35 +++
 rtl/jtag_debug_cmd_sync.sv | 106 ++++++++++
 tb/tb_jtag_debug_cmd_sync.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_debug_cmd_sync_pkg.sv
// Shared definitions for the JTAG debug command path: channel encodings,
// the queued command entry and a constant-foldable clog2.
package jtag_debug_pkg;

   typedef enum logic [1:0] {
      IR_OCIMEM    = 2'd0,
      IR_TRACEMEM  = 2'd1,
      IR_BREAK     = 2'd2,
      IR_TRACECTRL = 2'd3
   } jtag_ch_e;

   localparam int DEF_DATA_W = 38;
   localparam int DEF_IR_W   = 2;

   // Entry layout at the default widths; the top re-declares it at its own widths.
   typedef struct packed {
      logic [DEF_IR_W-1:0]   ir;
      logic [DEF_DATA_W-1:0] data;
   } cmd_entry_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/jtag_debug_cmd_sync_if.sv
// Command handshake between the JTAG command queue (master) and the debug core (slave).
interface jtag_debug_cmd_sync_if #(
   parameter int DATA_W = 38,
   parameter int IR_W   = 2
);
   localparam int NUM_CH = 2**IR_W;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] jdo;
   logic [NUM_CH-1:0] take_action;
   logic [NUM_CH-1:0] take_no_action;

   modport master (
      output cmd_valid, jdo, take_action, take_no_action,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, jdo, take_action, take_no_action,
      output cmd_ready
   );
endinterface

// File: rtl/jtag_debug_cmd_sync_strobe.sv
// Brings one asynchronous TCK-domain level strobe into clk and emits a
// single-cycle pulse on each armed rising edge.
module jtag_strobe_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic strobe,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] chain;
   logic [SYNC_STAGES-1:0] fill;
   logic                   delayed;
   logic                   armed;

   // fill tracks when the chain output holds a sampled value rather than the
   // reset zeros, so a strobe held high through reset never looks like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain   <= '0;
         fill    <= '0;
         delayed <= 1'b0;
         armed   <= 1'b0;
      end else begin
         chain   <= {chain[SYNC_STAGES-2:0], strobe};
         fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
         delayed <= chain[SYNC_STAGES-1];
         armed   <= armed | (fill[SYNC_STAGES-1] & ~chain[SYNC_STAGES-1]);
      end
   end

   assign pulse = chain[SYNC_STAGES-1] & ~delayed & armed;

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// System-clock side of the JTAG debug command path: strobe sync, IR latch,
// command queue and per-channel action decode towards the debug core.
module jtag_debug_cmd_sync
   import jtag_debug_pkg::*;
#(
   parameter int DATA_W      = 38,
   parameter int IR_W        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4,
   parameter int ACTION_BIT  = 35
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [IR_W-1:0]               ir_in,
   input  logic [DATA_W-1:0]             sr,
   input  logic                          vs_uir,
   input  logic                          vs_udr,
   input  logic                          clr_overflow,
   jtag_debug_cmd_sync_if.master         cmd,
   output logic [clog2(DEPTH+1)-1:0]     cmd_level,
   output logic                          overflow
);

   localparam int NUM_CH = 2**IR_W;
   localparam int PW     = clog2(DEPTH);
   localparam int LW     = clog2(DEPTH+1);

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic              uir_pulse;
   logic              udr_pulse;
   logic [IR_W-1:0]   ir_q;
   entry_t            mem [DEPTH];
   logic [LW-1:0]     wr_cnt;
   logic [LW-1:0]     rd_cnt;
   logic              full;
   logic              pop;
   logic              push_ok;
   entry_t            head;
   logic [NUM_CH-1:0] head_onehot;

   jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
      .clk    (clk),
      .reset  (reset),
      .strobe (vs_uir),
      .pulse  (uir_pulse)
   );

   jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
      .clk    (clk),
      .reset  (reset),
      .strobe (vs_udr),
      .pulse  (udr_pulse)
   );

   // Counters carry one bit more than the pointers so full and empty stay distinct.
   assign cmd_level     = wr_cnt - rd_cnt;
   assign cmd.cmd_valid = (cmd_level != '0);
   assign full          = (cmd_level == LW'(DEPTH));
   assign pop           = cmd.cmd_valid & cmd.cmd_ready;
   assign push_ok       = udr_pulse & (~full | pop);
   assign head          = mem[rd_cnt[PW-1:0]];

   always_comb begin
      head_onehot          = '0;
      head_onehot[head.ir] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q               <= '0;
         wr_cnt             <= '0;
         rd_cnt             <= '0;
         overflow           <= 1'b0;
         cmd.jdo            <= '0;
         cmd.take_action    <= '0;
         cmd.take_no_action <= '0;
      end else begin
         if (uir_pulse) ir_q <= ir_in;
         if (push_ok) wr_cnt <= wr_cnt + LW'(1);

         if (pop) begin
            rd_cnt             <= rd_cnt + LW'(1);
            cmd.jdo            <= head.data;
            cmd.take_action    <= head.data[ACTION_BIT] ? head_onehot : '0;
            cmd.take_no_action <= head.data[ACTION_BIT] ? '0 : head_onehot;
         end else begin
            cmd.take_action    <= '0;
            cmd.take_no_action <= '0;
         end

         // A drop in the same cycle as a clear leaves the flag set.
         if (udr_pulse & ~push_ok) overflow <= 1'b1;
         else if (clr_overflow)    overflow <= 1'b0;
      end
   end

   // Entry takes the IR value held before any coincident IR update.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_cnt[PW-1:0]] <= '{ir: ir_q, data: sr};
   end

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Directed and randomized bench for jtag_debug_cmd_sync with a queue-based
// reference model compared every cycle.
module tb_jtag_debug_cmd_sync;
   import jtag_debug_pkg::*;

   localparam int DATA_W = 38;
   localparam int IR_W   = 2;
   localparam int S      = 2;
   localparam int DEPTH  = 4;
   localparam int AB     = 35;
   localparam int NUM_CH = 4;
   localparam int LW     = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [IR_W-1:0]   ir_in;
   logic [DATA_W-1:0] sr;
   logic              vs_uir;
   logic              vs_udr;
   logic              clr_overflow;
   logic [LW-1:0]     cmd_level;
   logic              overflow;

   always #5 clk = ~clk;

   jtag_debug_cmd_sync_if #(.DATA_W(DATA_W), .IR_W(IR_W)) cmd_if ();

   jtag_debug_cmd_sync #(
      .DATA_W(DATA_W), .IR_W(IR_W), .SYNC_STAGES(S), .DEPTH(DEPTH), .ACTION_BIT(AB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ir_in        (ir_in),
      .sr           (sr),
      .vs_uir       (vs_uir),
      .vs_udr       (vs_udr),
      .clr_overflow (clr_overflow),
      .cmd          (cmd_if),
      .cmd_level    (cmd_level),
      .overflow     (overflow)
   );

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t              q[$];
   logic [IR_W-1:0]   m_ir;
   logic              m_ovf;
   logic [DATA_W-1:0] m_jdo;
   logic [NUM_CH-1:0] m_ta;
   logic [NUM_CH-1:0] m_tna;
   bit                uir_h [0:8191];
   bit                udr_h [0:8191];
   int                n = 0;
   int                last_rst = -1;
   int                checks = 0;
   int                errors = 0;
   logic [NUM_CH-1:0] seen_ta;
   logic [NUM_CH-1:0] seen_tna;
   int                seen_cmds;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A strobe acts S edges after the edge that first samples it high, provided
   // the edge before that sampled it low after the most recent reset.
   function automatic bit acts(input bit cur, input bit prev, input int k);
      return (k >= 1) && (k - 1 > last_rst) && cur && !prev;
   endfunction

   task automatic step();
      int   k;
      bit   uir_ev, udr_ev, pop, drop;
      ent_t e;
      @(posedge clk);
      uir_h[n] = vs_uir;
      udr_h[n] = vs_udr;
      k = n - S;
      uir_ev = (k >= 1) ? acts(uir_h[k], uir_h[k-1], k) : 1'b0;
      udr_ev = (k >= 1) ? acts(udr_h[k], udr_h[k-1], k) : 1'b0;
      if (reset) begin
         q.delete();
         m_ir = '0; m_ovf = 1'b0; m_jdo = '0; m_ta = '0; m_tna = '0;
         last_rst = n;
      end else begin
         pop  = (q.size() > 0) && cmd_if.cmd_ready;
         drop = 1'b0;
         m_ta = '0; m_tna = '0;
         if (pop) begin
            e = q.pop_front();
            m_jdo = e.data;
            if (e.data[AB]) m_ta[e.ir] = 1'b1;
            else            m_tna[e.ir] = 1'b1;
         end
         if (udr_ev) begin
            if (q.size() < DEPTH) q.push_back('{ir: m_ir, data: sr});
            else drop = 1'b1;
         end
         if (drop)              m_ovf = 1'b1;
         else if (clr_overflow) m_ovf = 1'b0;
         if (uir_ev) m_ir = ir_in;
      end
      n++;
      @(negedge clk);
      check("cmd_valid", cmd_if.cmd_valid, q.size() > 0);
      check("cmd_level", cmd_level, q.size());
      check("overflow", overflow, m_ovf);
      check("jdo", cmd_if.jdo, m_jdo);
      check("take_action", cmd_if.take_action, m_ta);
      check("take_no_action", cmd_if.take_no_action, m_tna);
      seen_ta  |= cmd_if.take_action;
      seen_tna |= cmd_if.take_no_action;
      if ((|cmd_if.take_action) || (|cmd_if.take_no_action)) seen_cmds++;
   endtask

   task automatic cycles(input int cnt);
      for (int i = 0; i < cnt; i++) step();
   endtask

   task automatic clear_seen();
      seen_ta = '0; seen_tna = '0; seen_cmds = 0;
   endtask

   task automatic strobe(input bit do_uir, input bit do_udr);
      if (do_uir) vs_uir = 1'b1;
      if (do_udr) vs_udr = 1'b1;
      cycles(S + 2);
      vs_uir = 1'b0;
      vs_udr = 1'b0;
      cycles(2);
   endtask

   function automatic logic [DATA_W-1:0] rand_sr(input bit action);
      logic [DATA_W-1:0] v;
      v = DATA_W'({$urandom(), $urandom()});
      v[AB] = action;
      return v;
   endfunction

   initial begin
      reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; clr_overflow = 1'b0;
      ir_in = '0; sr = '0; cmd_if.cmd_ready = 1'b0;
      clear_seen();
      cycles(3);
      check("rst_level", cmd_level, 0);
      check("rst_valid", cmd_if.cmd_valid, 0);
      check("rst_jdo", cmd_if.jdo, 0);
      reset = 1'b0;
      cycles(S + 3);

      // Single action command on IR_BREAK, with exact latency
      cmd_if.cmd_ready = 1'b1;
      ir_in = IR_BREAK;
      strobe(1'b1, 1'b0);
      clear_seen();
      sr = 38'h8_0000_00AB;
      vs_udr = 1'b1;
      step(); step();
      check("t1_valid_early", cmd_if.cmd_valid, 0);
      step();
      check("t1_valid", cmd_if.cmd_valid, 1);
      step();
      check("t1_jdo", cmd_if.jdo, 38'h8_0000_00AB);
      check("t1_ta", cmd_if.take_action, 4'b0100);
      check("t1_tna", cmd_if.take_no_action, 4'b0000);
      step();
      check("t1_ta_single", cmd_if.take_action, 4'b0000);
      vs_udr = 1'b0;
      cycles(2);

      // No-action command on IR_TRACEMEM
      ir_in = IR_TRACEMEM;
      strobe(1'b1, 1'b0);
      clear_seen();
      sr = rand_sr(1'b0);
      strobe(1'b0, 1'b1);
      cycles(2);
      check("t2_tna", seen_tna, 4'b0010);
      check("t2_ta", seen_ta, 4'b0000);
      check("t2_count", seen_cmds, 1);

      // Overflow: five pushes into four entries, then drain and clear
      cmd_if.cmd_ready = 1'b0;
      clear_seen();
      for (int i = 0; i < 5; i++) begin
         sr = rand_sr(i[0]);
         strobe(1'b0, 1'b1);
      end
      check("t3_level", cmd_level, 4);
      check("t3_overflow", overflow, 1);
      cmd_if.cmd_ready = 1'b1;
      cycles(6);
      check("t3_drained", seen_cmds, 4);
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      check("t3_ovf_clr", overflow, 0);

      // Push and pop on the same edge while full
      cmd_if.cmd_ready = 1'b0;
      clear_seen();
      for (int i = 0; i < 4; i++) begin
         sr = rand_sr(i[1]);
         strobe(1'b0, 1'b1);
      end
      sr = rand_sr(1'b1);
      vs_udr = 1'b1;
      cycles(S);
      cmd_if.cmd_ready = 1'b1;
      step();
      cmd_if.cmd_ready = 1'b0;
      check("t4_level", cmd_level, 4);
      check("t4_overflow", overflow, 0);
      vs_udr = 1'b0;
      cycles(2);
      cmd_if.cmd_ready = 1'b1;
      cycles(6);
      check("t4_count", seen_cmds, 5);

      // Strobe held high across reset must not produce a command
      vs_udr = 1'b1;
      reset = 1'b1;
      cycles(3);
      reset = 1'b0;
      clear_seen();
      cycles(8);
      check("t5_none", seen_cmds, 0);
      check("t5_level", cmd_level, 0);
      vs_udr = 1'b0;
      cycles(3);
      strobe(1'b0, 1'b1);
      cycles(2);
      check("t5_one", seen_cmds, 1);

      // Coincident IR and DR updates
      ir_in = IR_OCIMEM;
      strobe(1'b1, 1'b0);
      ir_in = IR_TRACECTRL;
      sr = rand_sr(1'b1);
      clear_seen();
      strobe(1'b1, 1'b1);
      cycles(2);
      check("t6_old_ir", seen_ta, 4'b0001);
      sr = rand_sr(1'b1);
      clear_seen();
      strobe(1'b0, 1'b1);
      cycles(2);
      check("t6_new_ir", seen_ta, 4'b1000);

      // Randomized traffic against the reference model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) vs_uir = ~vs_uir;
         if ($urandom_range(0, 3) == 0) vs_udr = ~vs_udr;
         if (!vs_uir) ir_in = IR_W'($urandom());
         if (!vs_udr) sr = rand_sr(1'($urandom()));
         cmd_if.cmd_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 5) == 0);
         clr_overflow = ($urandom_range(0, 40) == 0);
         reset = ($urandom_range(0, 250) == 0);
         step();
      end
      reset = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; clr_overflow = 1'b0;
      cmd_if.cmd_ready = 1'b1;
      cycles(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
